// File: rtl/uart_hex_dumper.sv
// uart_hex_dumper: reads a run of 32-bit words from a word memory and prints
// each one over an 8N1 UART as eight uppercase hex digits followed by CR LF.
// A dump is started by a one-cycle start request while idle; busy covers the
// whole dump and done pulses once when the last word has gone out.

module uart_hex_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    // Bit-period counter holds 0..CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   word_idx;   // one bit wider so a full 2^ADDR_W dump can be counted
    logic [3:0]        char_idx;   // 0..7 hex digits, 8 = CR, 9 = LF
    logic [31:0]       word_buf;
    logic [9:0]        shift_q;    // {stop, data[7:0], start}; bit 0 is the bit on the line
    logic [CNT_W-1:0]  bit_cnt;
    logic [3:0]        bit_idx;    // 0 = start bit, 1..8 = data, 9 = stop bit
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic [ADDR_W:0]   next_word;
    logic [3:0]        nibble;
    logic [7:0]        cur_char;

    assign next_word = word_idx + 1'b1;

    // The read strobe is simply the FETCH state; the address wraps naturally
    // because the sum is truncated to ADDR_W bits.
    assign mem_rd_en = (state == S_FETCH);
    assign mem_addr  = base_q + word_idx[ADDR_W-1:0];
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Select the character for the current char_idx and encode it as ASCII.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path, otherwise synthesis infers a latch to hold the old value.
        nibble = 4'(word_buf >> {~char_idx[2:0], 2'b00});  // digit 0 is bits [31:28]
        if (char_idx[3]) begin
            cur_char = char_idx[0] ? 8'h0A : 8'h0D;
        end else if (nibble < 4'd10) begin
            cur_char = 8'h30 + {4'h0, nibble};
        end else begin
            cur_char = 8'h37 + {4'h0, nibble};              // 'A' - 10
        end
    end

    // Dump sequencer, UART serializer and status outputs.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here - it is only seen on a clock edge,
        // so rst_n sits inside the clocked block and not in the sensitivity list.
        if (!rst_n) begin
            state    <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            word_idx <= '0;
            char_idx <= '0;
            word_buf <= '0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register
            // updates from the values present before the edge, whatever the order.
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        count_q  <= count;
                        word_idx <= '0;
                        busy_q   <= 1'b1;
                        state    <= (count == '0) ? S_NEXT : S_FETCH;
                    end
                end
                S_FETCH: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    word_buf <= mem_rdata;
                    char_idx <= '0;
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q <= {1'b1, cur_char, 1'b0};
                    tx_q    <= 1'b0;                      // start bit goes out with the state change
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;                    // reload at every boundary, no drift
                        if (bit_idx == 4'd9) begin
                            tx_q <= 1'b1;
                            if (char_idx < 4'd9) begin
                                char_idx <= char_idx + 1'b1;
                                state    <= S_LOAD;
                            end else begin
                                state    <= S_NEXT;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift_q <= {1'b1, shift_q[9:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    word_idx <= next_word;
                    // ">=" also finishes a count=0 request on its first pass.
                    if (next_word >= count_q) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_hex_dumper.sv
// Directed bench for uart_hex_dumper with CLKS_PER_BIT=4, ADDR_W=4.
// A small word memory answers read strobes; tx is sampled on every falling
// edge and decoded offline into characters, with per-bit width checks.

module tb_uart_hex_dumper;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata = '0;
    logic          tx;
    logic          busy;
    logic          done;

    logic [31:0]   mem [16];

    logic          tx_hist [$];
    logic [AW-1:0] rd_addrs [$];
    int            done_cnt = 0;

    logic [7:0]    rx_chars [$];
    int            gaps [$];
    int            frame_err;

    int n_checks;
    int n_pass;

    uart_hex_dumper #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Word memory: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rdata <= mem[mem_addr];
            rd_addrs.push_back(mem_addr);
        end
    end

    // Line and done monitors, sampled mid-cycle.
    always @(negedge clk) begin
        tx_hist.push_back(tx);
        if (done === 1'b1) done_cnt++;
    end

    function automatic logic [7:0] exp_char(input logic [31:0] w, input int idx);
        logic [3:0] n;
        if (idx == 8) return 8'h0D;
        if (idx == 9) return 8'h0A;
        n = w[28 - 4*idx +: 4];
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h41 + ({4'h0, n} - 8'd10);
    endfunction

    // Decode 8N1 frames from tx_hist[from..]; each bit must be CPB identical samples.
    task automatic decode(input int from);
        int i;
        int last_end;
        logic [7:0] ch;
        logic v;
        rx_chars.delete();
        gaps.delete();
        frame_err = 0;
        last_end = -1;
        i = from;
        while (i < tx_hist.size()) begin
            if (tx_hist[i] === 1'b0) begin
                if (i + 10*CPB > tx_hist.size()) begin
                    frame_err++;
                    break;
                end
                ch = 8'h00;
                for (int b = 0; b < 10; b++) begin
                    v = tx_hist[i + CPB*b];
                    for (int k = 1; k < CPB; k++)
                        if (tx_hist[i + CPB*b + k] !== v) frame_err++;
                    if (b == 9 && v !== 1'b1) frame_err++;
                    if (b >= 1 && b <= 8) ch[b-1] = v;
                end
                if (last_end >= 0) gaps.push_back(i - last_end);
                rx_chars.push_back(ch);
                i += 10*CPB;
                last_end = i;
            end else begin
                i++;
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] c);
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        count = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic busy_at_done);
        seen = 1'b0;
        busy_at_done = 1'bx;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else n_pass++;
        n_checks++; if (mem_addr !== '0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [7:0] exp1 [10];
        int hb, rb, db, max_gap;
        bit seen;
        logic bd;
        exp1 = '{8'h31, 8'h32, 8'h41, 8'h42, 8'h33, 8'h34, 8'h43, 8'h44, 8'h0D, 8'h0A};
        hb = tx_hist.size(); rb = rd_addrs.size(); db = done_cnt;
        pulse_start(4'd0, 5'd1);
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        wait_done(2000, seen, bd);
        n_checks++; if (seen !== 1'b1) $display("FAIL single_done_seen: got %b want 1", seen); else n_pass++;
        n_checks++; if (bd !== 1'b0) $display("FAIL single_busy_at_done: got %b want 0", bd); else n_pass++;
        repeat (10) @(negedge clk);
        decode(hb);
        n_checks++; if (rx_chars.size() != 10) $display("FAIL single_nchars: got %0d want 10", rx_chars.size()); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] got;
            got = (i < rx_chars.size()) ? rx_chars[i] : 8'hxx;
            n_checks++; if (got !== exp1[i]) $display("FAIL single_char%0d: got %h want %h", i, got, exp1[i]); else n_pass++;
        end
        n_checks++; if (frame_err != 0) $display("FAIL single_bit_timing: got %0d bad samples want 0", frame_err); else n_pass++;
        max_gap = 0;
        foreach (gaps[j]) if (gaps[j] > max_gap) max_gap = gaps[j];
        n_checks++; if (max_gap > 1) $display("FAIL single_char_gap: got %0d want <=1", max_gap); else n_pass++;
        n_checks++; if (done_cnt - db != 1) $display("FAIL single_done_count: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (rd_addrs.size() - rb != 1) $display("FAIL single_reads: got %0d want 1", rd_addrs.size() - rb); else n_pass++;
        n_checks++; if (rd_addrs.size() > rb && rd_addrs[rb] !== 4'd0) $display("FAIL single_addr: got %0d want 0", rd_addrs[rb]); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_addr [3];
        int hb, rb, db, bad, bad_gap;
        bit seen;
        logic bd;
        exp_addr = '{4'd14, 4'd15, 4'd0};
        hb = tx_hist.size(); rb = rd_addrs.size(); db = done_cnt;
        pulse_start(4'd14, 5'd3);
        wait_done(5000, seen, bd);
        n_checks++; if (seen !== 1'b1) $display("FAIL wrap_done_seen: got %b want 1", seen); else n_pass++;
        repeat (10) @(negedge clk);
        decode(hb);
        n_checks++; if (rd_addrs.size() - rb != 3) $display("FAIL wrap_reads: got %0d want 3", rd_addrs.size() - rb); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [AW-1:0] got;
            got = (rb + i < rd_addrs.size()) ? rd_addrs[rb + i] : 'x;
            n_checks++; if (got !== exp_addr[i]) $display("FAIL wrap_addr%0d: got %0d want %0d", i, got, exp_addr[i]); else n_pass++;
        end
        n_checks++; if (rx_chars.size() != 30) $display("FAIL wrap_nchars: got %0d want 30", rx_chars.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] got;
            got = (i < rx_chars.size()) ? rx_chars[i] : 8'hxx;
            if (got !== exp_char(mem[exp_addr[i/10]], i % 10)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL wrap_chars: got %0d wrong characters want 0", bad); else n_pass++;
        n_checks++; if (frame_err != 0) $display("FAIL wrap_bit_timing: got %0d bad samples want 0", frame_err); else n_pass++;
        bad_gap = 0;
        foreach (gaps[j]) begin
            if ((j == 9 || j == 19) ? (gaps[j] > 4) : (gaps[j] > 1)) bad_gap++;
        end
        n_checks++; if (bad_gap != 0) $display("FAIL wrap_gaps: got %0d oversized gaps want 0", bad_gap); else n_pass++;
        n_checks++; if (done_cnt - db != 1) $display("FAIL wrap_done_count: got %0d want 1", done_cnt - db); else n_pass++;
    endtask

    task automatic test_count_zero();
        int hb, rb, db, zeros;
        bit seen;
        hb = tx_hist.size(); rb = rd_addrs.size(); db = done_cnt;
        pulse_start(4'd5, 5'd0);
        seen = 1'b0;
        if (done === 1'b1) seen = 1'b1;
        for (int k = 0; k < 2 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL zero_done_within_2: got %b want 1", seen); else n_pass++;
        repeat (20) @(negedge clk);
        zeros = 0;
        for (int i = hb; i < tx_hist.size(); i++) if (tx_hist[i] !== 1'b1) zeros++;
        n_checks++; if (zeros != 0) $display("FAIL zero_tx_idle: got %0d low samples want 0", zeros); else n_pass++;
        n_checks++; if (rd_addrs.size() != rb) $display("FAIL zero_reads: got %0d want 0", rd_addrs.size() - rb); else n_pass++;
        n_checks++; if (done_cnt - db != 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt - db); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int hb, rb, db, bad;
        bit seen;
        logic bd;
        hb = tx_hist.size(); rb = rd_addrs.size(); db = done_cnt;
        pulse_start(4'd0, 5'd1);
        repeat (60) @(negedge clk);
        pulse_start(4'd5, 5'd2);
        n_checks++; if (busy !== 1'b1) $display("FAIL ignore_busy_mid: got %b want 1", busy); else n_pass++;
        wait_done(2000, seen, bd);
        n_checks++; if (seen !== 1'b1) $display("FAIL ignore_done_seen: got %b want 1", seen); else n_pass++;
        repeat (300) @(negedge clk);
        decode(hb);
        n_checks++; if (rx_chars.size() != 10) $display("FAIL ignore_nchars: got %0d want 10", rx_chars.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] got;
            got = (i < rx_chars.size()) ? rx_chars[i] : 8'hxx;
            if (got !== exp_char(mem[0], i)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL ignore_chars: got %0d wrong characters want 0", bad); else n_pass++;
        n_checks++; if (rd_addrs.size() - rb != 1) $display("FAIL ignore_reads: got %0d want 1", rd_addrs.size() - rb); else n_pass++;
        n_checks++; if (done_cnt - db != 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt - db); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int hb, rb, db, zeros;
        bit found;
        pulse_start(4'd0, 5'd1);
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) $display("FAIL midrst_start_bit: got %b want 1", found); else n_pass++;
        // 13 samples past the first start-bit sample lands inside data bit 2 of '1' (0x31), a 0.
        repeat (13) @(negedge clk);
        n_checks++; if (tx !== 1'b0) $display("FAIL midrst_in_bit2: got %b want 0", tx); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b want 1", tx); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        hb = tx_hist.size(); rb = rd_addrs.size(); db = done_cnt;
        repeat (200) @(negedge clk);
        zeros = 0;
        for (int i = hb; i < tx_hist.size(); i++) if (tx_hist[i] !== 1'b1) zeros++;
        n_checks++; if (zeros != 0) $display("FAIL midrst_no_frames: got %0d low samples want 0", zeros); else n_pass++;
        n_checks++; if (rd_addrs.size() != rb) $display("FAIL midrst_no_reads: got %0d want 0", rd_addrs.size() - rb); else n_pass++;
        n_checks++; if (done_cnt != db) $display("FAIL midrst_no_done: got %0d want 0", done_cnt - db); else n_pass++;
    endtask

    task automatic test_start_after_reset();
        int hb, bad;
        bit seen;
        logic bd;
        rst_n = 1'b0;
        @(negedge clk);
        hb = tx_hist.size();
        rst_n = 1'b1;
        start = 1'b1;
        base_addr = 4'd3;
        count = 5'd1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) $display("FAIL first_start_busy: got %b want 1", busy); else n_pass++;
        wait_done(2000, seen, bd);
        n_checks++; if (seen !== 1'b1) $display("FAIL first_start_done: got %b want 1", seen); else n_pass++;
        repeat (10) @(negedge clk);
        decode(hb);
        n_checks++; if (rx_chars.size() != 10) $display("FAIL first_start_nchars: got %0d want 10", rx_chars.size()); else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            logic [7:0] got;
            got = (i < rx_chars.size()) ? rx_chars[i] : 8'hxx;
            if (got !== exp_char(mem[3], i)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL first_start_chars: got %0d wrong characters want 0", bad); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h12AB34CD;
        mem[3]  = 32'h0000FFFF;
        mem[5]  = 32'h55555555;
        mem[14] = 32'h9F0E5A76;
        mem[15] = 32'hFEDCBA98;

        test_reset();
        test_single_word();
        test_wrap();
        test_count_zero();
        test_start_ignored();
        test_reset_mid_frame();
        test_start_after_reset();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_hex_dumper.md
UART_HEX_DUMPER -- requirements
Module: uart_hex_dumper

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter ADDR_W, default 4, width of the word-memory address.
REQ-003 clk  input  1  clock; all logic is rising-edge triggered.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to begin a dump; sampled every cycle.
REQ-006 base_addr  input  ADDR_W  first word address; captured on an accepted start.
REQ-007 count  input  ADDR_W+1  number of words to dump (0..2^ADDR_W); captured on an accepted start.
REQ-008 mem_rd_en  output  1  one-cycle read strobe to the word memory.
REQ-009 mem_addr  output  ADDR_W  read address; valid while mem_rd_en=1.
REQ-010 mem_rdata  input  32  read data, valid exactly one cycle after mem_rd_en.
REQ-011 tx  output  1  UART serial output, 8N1, idle high.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse when a dump completes.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, WAIT, LOAD, SEND, NEXT.
REQ-015 In IDLE, start=1 is accepted; base_addr and count are latched, the word counter is cleared, and the FSM moves to FETCH, or to NEXT if count=0.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 FETCH: assert mem_rd_en for one cycle with mem_addr = (base_addr + word_index) mod 2^ADDR_W, then go to WAIT.
REQ-018 WAIT: capture mem_rdata into a 32-bit word buffer, set char_index=0, then go to LOAD.
REQ-019 Per word, the block SHALL emit 10 characters in this order: 8 hex characters for bits [31:28] down to [3:0], then 0x0D, then 0x0A.
REQ-020 Hex encoding: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10), uppercase only.
REQ-021 LOAD: the selected character goes into the shift register, then go to SEND.
REQ-022 SEND: one 8N1 frame is serialized as a start bit (0), data bits LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles, 10*CLKS_PER_BIT cycles total.
REQ-023 After the stop bit: if char_index<9, increment it and return to LOAD; otherwise go to NEXT.
REQ-024 NEXT: increment word_index; if word_index equals count, pulse done for one cycle and return to IDLE; otherwise go to FETCH.
REQ-025 The idle-high gap between consecutive characters of one word SHALL be 1 cycle or less; the gap between words SHALL be 4 cycles or less.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W; count=2^ADDR_W dumps every word once.
REQ-027 tx SHALL be 1 in every state except SEND start and data bits carrying 0.
REQ-028 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload at every bit boundary with no drift.

Reset
REQ-029 When rst_n=0 at a clock edge: FSM to IDLE; tx=1, busy=0, done=0, mem_rd_en=0, mem_addr=0; all counters and the shift register cleared.
REQ-030 A reset asserted mid-frame SHALL abort the frame; tx is 1 from the next edge, and no partial dump resumes after reset.
REQ-031 The first start SHALL be accepted in the cycle after rst_n returns high.

Verification (CLKS_PER_BIT=4, ADDR_W=4)
REQ-032 mem[0]=0x12AB34CD, base=0, count=1, start pulse -> tx decodes to 31 32 41 42 33 34 43 44 0D 0A; done pulses once; busy falls with done.
REQ-033 base=14, count=3 -> mem_addr sequence 14, 15, 0; 30 characters; one done pulse.
REQ-034 count=0, start -> no mem_rd_en, tx stays 1, done pulses within 2 cycles.
REQ-035 start pulsed again mid-dump -> ignored; character stream and done count unchanged.
REQ-036 rst_n low during the 3rd data bit of a character -> tx=1, busy=0 the next cycle; no further frames.
REQ-037 Bit timing check: every start, data, and stop bit lasts exactly 4 cycles; a frame lasts 40 cycles.
